// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared sample width, QPSK bit-pair type and demapper FSM states
package awgn_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [1:0] qpsk_bits_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of set bits in a QPSK bit pair (0..2)
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

// File: rtl/ref_bit_fifo.sv
// rtl/ref_bit_fifo.sv - single-clock 2-bit reference FIFO with flush, full/empty flags
module ref_bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] pop_data,
    output logic       full,
    output logic       empty
);
    import awgn_pkg::*;

    localparam int AW = $clog2(DEPTH);

    qpsk_bits_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when an entry leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/qpsk_demap_ber.sv
// rtl/qpsk_demap_ber.sv - Gray-QPSK hard demapper with windowed bit-error counter (option: QPSK_ERASURE_EN)
module qpsk_demap_ber #(
    parameter int SAMPLE_W    = awgn_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH  = 16,
    parameter int WINDOW_SYMS = 320000,
    parameter int CNT_W       = 32
`ifdef QPSK_ERASURE_EN
    ,
    parameter int ERASE_THRESH = 4
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          tx_bits,
    input  logic                tx_valid,
    input  logic [SAMPLE_W-1:0] Y_in_real,
    input  logic [SAMPLE_W-1:0] Y_in_imag,
    input  logic                y_valid,
    output logic [1:0]          rx_bits,
    output logic                rx_valid,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    sym_count,
    output logic                busy,
    output logic                done,
    output logic                fifo_overflow,
    output logic                fifo_underflow
`ifdef QPSK_ERASURE_EN
    ,
    output logic [CNT_W-1:0]    erase_count
`endif
);
    import awgn_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_SYMS);

    state_t           state;
    qpsk_bits_t       head;
    qpsk_bits_t       decision;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             erased;
    logic             symbol_ok;
    logic             count_en;
    logic [1:0]       errors;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W:0]   sym_sum;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] sym_next;

    // Sign-bit slicer: negative -> 1, zero and positive -> 0
    assign decision = {Y_in_real[SAMPLE_W-1], Y_in_imag[SAMPLE_W-1]};
    assign pop      = y_valid & ~fifo_empty;
    assign errors   = popcount2(decision ^ head);

`ifdef QPSK_ERASURE_EN
    assign erased = (int'($signed(Y_in_real)) > -ERASE_THRESH && int'($signed(Y_in_real)) < ERASE_THRESH) ||
                    (int'($signed(Y_in_imag)) > -ERASE_THRESH && int'($signed(Y_in_imag)) < ERASE_THRESH);
`else
    assign erased = 1'b0;
`endif

    // A symbol is judged only in RUN against a real reference; a coincident start discards it
    assign symbol_ok = (state == ST_RUN) & y_valid & ~fifo_empty & ~start;
    assign count_en  = symbol_ok & ~erased;

    assign err_sum  = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, errors};
    assign sym_sum  = {1'b0, sym_count} + (CNT_W+1)'(1);
    assign err_next = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
    assign sym_next = sym_sum[CNT_W] ? CNT_MAX : sym_sum[CNT_W-1:0];

    ref_bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ref_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (start),
        .push      (tx_valid),
        .push_data (tx_bits),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decision output register: one-cycle latency, produced in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_bits  <= 2'b00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= y_valid;
            if (y_valid) rx_bits <= decision;
        end
    end

    // Window FSM with counters and sticky FIFO flags; start restarts from any state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            sym_count      <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else if (start) begin
            state          <= ST_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_count      <= '0;
            sym_count      <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (tx_valid && fifo_full && !pop) fifo_overflow <= 1'b1;
            if (y_valid && fifo_empty)         fifo_underflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                ST_RUN: begin
                    if (count_en) begin
                        err_count <= err_next;
                        sym_count <= sym_next;
                        if (sym_next == WIN_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef QPSK_ERASURE_EN
    // Erasure tally: symbols too close to a decision boundary are counted here instead
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            erase_count <= '0;
        end else if (start) begin
            erase_count <= '0;
        end else if (symbol_ok && erased && erase_count != CNT_MAX) begin
            erase_count <= erase_count + CNT_W'(1);
        end
    end
`endif

endmodule
